key_entry_buffer: RTL and testbench

//  Parametrised keypad/switch entry stage for the door lock. Samples NUM_KEYS one-hot key lines,

---
 rtl/key_entry_buffer.sv | 155 +++++++++++++++
 tb/tb_key_entry_buffer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/key_entry_buffer.sv
// Keypad entry stage: sync, debounce, one-hot encode, digit buffer.
// Ports: clk, rst | key_in, clear | key_valid, key_err, ovf, key_idx, code_out, count, full
module key_entry_buffer #(
  parameter int NUM_KEYS = 10,
  parameter int IDX_W = 4,
  parameter int DIGITS = 4,
  parameter int DEBOUNCE = 16,
  parameter logic [IDX_W-1:0] ERR_CODE = 4'hA
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_KEYS-1:0]       key_in,
  input  logic                      clear,
  output logic                      key_valid,
  output logic                      key_err,
  output logic                      ovf,
  output logic [IDX_W-1:0]          key_idx,
  output logic [DIGITS*IDX_W-1:0]   code_out,
  output logic [$clog2(DIGITS+1)-1:0] count,
  output logic                      full
);

  localparam int CNT_W = $clog2(DEBOUNCE);
  localparam int CW = $clog2(DIGITS+1);
  localparam logic [CNT_W-1:0] DB_LAST =
    CNT_W'(DEBOUNCE - 1);
  localparam logic [CW-1:0] CNT_MAX =
    CW'(DIGITS);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    HELD
  } state_t;

  state_t state;

  logic [NUM_KEYS-1:0] sync_q;
  logic [NUM_KEYS-1:0] ks;
  logic [NUM_KEYS-1:0] samp;
  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    rcnt;

  logic                one_hot;
  logic [IDX_W-1:0]    idx;
  logic [DIGITS*IDX_W-1:0] code_push;

  // samp & (samp-1) clears the lowest set bit; zero result
  // on a nonzero samp means exactly one key is down.
  assign one_hot = (|samp) &&
    ~|(samp & (samp - NUM_KEYS'(1)));

  always_comb begin
    idx = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (samp[i]) idx = IDX_W'(i);
    end
  end

  generate
    if (DIGITS == 1) begin : g_one
      assign code_push = idx;
    end else begin : g_shift
      assign code_push = {
        code_out[(DIGITS-1)*IDX_W-1:0], idx
      };
    end
  endgenerate

  assign full = (count == CNT_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q    <= '0;
      ks        <= '0;
      samp      <= '0;
      cnt       <= '0;
      rcnt      <= '0;
      state     <= IDLE;
      key_valid <= 1'b0;
      key_err   <= 1'b0;
      ovf       <= 1'b0;
      key_idx   <= '0;
      code_out  <= '0;
      count     <= '0;
    end else begin
      sync_q    <= key_in;
      ks        <= sync_q;
      key_valid <= 1'b0;
      key_err   <= 1'b0;
      ovf       <= 1'b0;

      // clear wins over a same-edge push: the push below
      // is suppressed when clear is high.
      if (clear) begin
        code_out <= '0;
        count    <= '0;
      end

      case (state)
        IDLE: begin
          if (|ks) begin
            samp  <= ks;
            cnt   <= '0;
            state <= SETTLE;
          end
        end

        SETTLE: begin
          if (ks == '0) begin
            state <= IDLE;
          end else if (ks != samp) begin
            samp <= ks;
            cnt  <= '0;
          end else if (cnt == DB_LAST) begin
            state <= HELD;
            rcnt  <= '0;
            if (one_hot) begin
              key_valid <= 1'b1;
              key_idx   <= idx;
              if (!clear) begin
                if (count < CNT_MAX) begin
                  code_out <= code_push;
                  count    <= count + 1'b1;
                end else begin
                  ovf <= 1'b1;
                end
              end
            end else begin
              key_err <= 1'b1;
              key_idx <= ERR_CODE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        HELD: begin
          // Any activity restarts the release window;
          // new or changed keys are otherwise ignored.
          if (|ks) begin
            rcnt <= '0;
          end else if (rcnt == DB_LAST) begin
            state <= IDLE;
          end else begin
            rcnt <= rcnt + 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_key_entry_buffer.sv
// Directed bench for key_entry_buffer with DEBOUNCE=4.
// Checks latency, bounce, multi-hot, buffer fill/overflow, clear, reset.
module tb_key_entry_buffer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  key_in = '0;
  logic        clear = 1'b0;
  logic        key_valid;
  logic        key_err;
  logic        ovf;
  logic [3:0]  key_idx;
  logic [15:0] code_out;
  logic [2:0]  count;
  logic        full;

  int checks = 0;
  int errors = 0;
  int n_valid = 0;
  int n_err = 0;
  int n_ovf = 0;
  logic prev_pulse = 1'b0;

  key_entry_buffer #(
    .NUM_KEYS(10),
    .IDX_W(4),
    .DIGITS(4),
    .DEBOUNCE(4),
    .ERR_CODE(4'hA)
  ) dut (
    .clk(clk),
    .rst(rst),
    .key_in(key_in),
    .clear(clear),
    .key_valid(key_valid),
    .key_err(key_err),
    .ovf(ovf),
    .key_idx(key_idx),
    .code_out(code_out),
    .count(count),
    .full(full)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (key_valid) n_valid++;
    if (key_err) n_err++;
    if (ovf) n_ovf++;
    if (!rst) begin
      check("no_back_to_back",
            32'((key_valid | key_err) & prev_pulse), 0);
      check("valid_err_excl",
            32'(key_valid & key_err), 0);
      check("ovf_with_valid",
            32'(ovf & ~key_valid), 0);
    end
    prev_pulse = key_valid | key_err;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Hold v for up to 'hold' cycles, report cycle index of
  // the first pulse (-1 if none), then release and settle.
  task automatic press(input logic [9:0] v,
                       input int hold,
                       output int lat);
    key_in = v;
    lat = -1;
    for (int i = 1; i <= hold; i++) begin
      tick();
      if ((key_valid || key_err) && lat < 0) lat = i;
    end
    key_in = '0;
    repeat (10) tick();
  endtask

  int lat;
  int v0, e0, o0;

  initial begin
    repeat (3) tick();
    check("rst_valid", 32'(key_valid), 0);
    check("rst_err", 32'(key_err), 0);
    check("rst_ovf", 32'(ovf), 0);
    check("rst_idx", 32'(key_idx), 0);
    check("rst_code", 32'(code_out), 0);
    check("rst_count", 32'(count), 0);
    check("rst_full", 32'(full), 0);
    rst = 1'b0;
    tick();

    // 1: single press, latency e0+6
    key_in = 10'b00_0000_1000;
    for (int i = 1; i <= 6; i++) begin
      tick();
      check("t1_no_early", 32'(key_valid), 0);
    end
    tick();
    check("t1_valid", 32'(key_valid), 1);
    check("t1_idx", 32'(key_idx), 3);
    check("t1_count", 32'(count), 1);
    check("t1_code", 32'(code_out), 32'h0003);
    repeat (5) tick();
    key_in = '0;
    repeat (10) tick();
    check("t1_npulse", 32'(n_valid), 1);

    // 2: bounce then stable hold of key 5
    v0 = n_valid;
    for (int k = 0; k < 10; k++) begin
      key_in = ((k / 2) % 2 == 1) ? 10'b00_0010_0000 : '0;
      tick();
    end
    check("t2_no_bounce", 32'(n_valid - v0), 0);
    press(10'b00_0010_0000, 12, lat);
    check("t2_lat", 32'(lat), 7);
    check("t2_npulse", 32'(n_valid - v0), 1);
    check("t2_idx", 32'(key_idx), 5);
    check("t2_code", 32'(code_out), 32'h0035);

    // 3: multi-hot rejected
    v0 = n_valid;
    e0 = n_err;
    o0 = n_ovf;
    press(10'b00_0010_0001, 12, lat);
    check("t3_lat", 32'(lat), 7);
    check("t3_err", 32'(n_err - e0), 1);
    check("t3_novalid", 32'(n_valid - v0), 0);
    check("t3_idx", 32'(key_idx), 32'hA);
    check("t3_count", 32'(count), 2);
    check("t3_noovf", 32'(n_ovf - o0), 0);

    // 4: fill and overflow
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("t4_clr_count", 32'(count), 0);
    check("t4_clr_code", 32'(code_out), 0);
    for (int k = 1; k <= 4; k++) begin
      press(10'(1 << k), 12, lat);
      check("t4_lat", 32'(lat), 7);
    end
    check("t4_code", 32'(code_out), 32'h1234);
    check("t4_full", 32'(full), 1);
    check("t4_count", 32'(count), 4);
    v0 = n_valid;
    o0 = n_ovf;
    press(10'b00_0010_0000, 12, lat);
    check("t4_ovf", 32'(n_ovf - o0), 1);
    check("t4_valid5", 32'(n_valid - v0), 1);
    check("t4_code_kept", 32'(code_out), 32'h1234);
    check("t4_idx5", 32'(key_idx), 5);

    // 5: clear on push edge
    clear = 1'b1;
    tick();
    clear = 1'b0;
    press(10'b00_0000_0010, 12, lat);
    press(10'b00_0000_0100, 12, lat);
    check("t5_pre_count", 32'(count), 2);
    check("t5_pre_code", 32'(code_out), 32'h0012);
    key_in = 10'b00_1000_0000;
    repeat (6) tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("t5_valid", 32'(key_valid), 1);
    check("t5_ovf", 32'(ovf), 0);
    check("t5_count", 32'(count), 0);
    check("t5_code", 32'(code_out), 0);
    check("t5_idx", 32'(key_idx), 7);
    key_in = '0;
    repeat (10) tick();

    // 6: reset mid-HELD, key re-debounced
    press(10'b00_0000_0000, 1, lat);
    key_in = 10'b10_0000_0000;
    repeat (7) tick();
    check("t6_first", 32'(key_valid), 1);
    check("t6_first_cnt", 32'(count), 1);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_rst_count", 32'(count), 0);
    check("t6_rst_idx", 32'(key_idx), 0);
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (key_valid && lat < 0) lat = i;
    end
    check("t6_lat", 32'(lat), 7);
    check("t6_idx", 32'(key_idx), 9);
    check("t6_count", 32'(count), 1);
    check("t6_code", 32'(code_out), 32'h0009);
    key_in = '0;
    repeat (10) tick();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
